// File: rtl/warn_blink_ctl.sv
// Warning qualifier feeding the gauge blinker: arms on N consecutive over-limit
// samples, holds the warning for a minimum time after release, and supports ack-silencing.
module warn_blink_ctl #(
  parameter int unsigned W         = 12,
  parameter int unsigned THRESH_HI = 2000,
  parameter int unsigned THRESH_LO = 1800,
  parameter int unsigned N_ARM     = 4,
  parameter int unsigned A_BITS    = 3,
  parameter int unsigned HOLD_CLKS = 16,
  parameter int unsigned H_BITS    = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  input  logic [W-1:0] s_data,
  input  logic         ack,
  output logic         blink,
  output logic         active,
  output logic         acked
);

  localparam logic [W-1:0]      HI_LVL    = W'(THRESH_HI);
  localparam logic [W-1:0]      LO_LVL    = W'(THRESH_LO);
  localparam logic [A_BITS-1:0] ARM_LAST  = A_BITS'(N_ARM - 1);
  localparam logic [H_BITS-1:0] HOLD_LAST = H_BITS'(HOLD_CLKS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [A_BITS-1:0]   arm_cnt, arm_nxt;
  logic [H_BITS-1:0]   hold_cnt, hold_nxt;
  logic                ack_reg, ack_nxt;
  logic                over_c, under_c;

  assign over_c  = s_valid && (s_data > HI_LVL);
  assign under_c = s_valid && (s_data < LO_LVL);

  assign active = (state == ACTIVE) || (state == HOLD);
  assign blink  = active && !ack_reg;
  assign acked  = ack_reg;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      hold_cnt <= '0;
      ack_reg  <= 1'b0;
    end else begin
      state    <= state_nxt;
      arm_cnt  <= arm_nxt;
      hold_cnt <= hold_nxt;
      ack_reg  <= ack_nxt;
    end
  end

  // Next-state, counters and acknowledge
  always_comb begin
    state_nxt = state;
    arm_nxt   = arm_cnt;
    hold_nxt  = hold_cnt;
    ack_nxt   = ack_reg;

    case (state)
      IDLE: begin
        arm_nxt = '0;
        if (over_c) begin
          if (N_ARM == 1) begin
            state_nxt = ACTIVE;
          end else begin
            state_nxt = ARM;
            arm_nxt   = A_BITS'(1);
          end
        end
      end
      ARM: begin
        if (over_c) begin
          if (arm_cnt == ARM_LAST) begin
            state_nxt = ACTIVE;
            arm_nxt   = '0;
          end else begin
            arm_nxt = arm_cnt + A_BITS'(1);
          end
        end else if (s_valid) begin
          // any non-qualifying beat breaks the streak
          state_nxt = IDLE;
          arm_nxt   = '0;
        end
      end
      ACTIVE: begin
        if (under_c) begin
          state_nxt = HOLD;
          hold_nxt  = '0;
        end
      end
      HOLD: begin
        // re-trigger takes priority over hold expiry
        if (over_c) begin
          state_nxt = ACTIVE;
          hold_nxt  = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt = IDLE;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + H_BITS'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        arm_nxt   = '0;
        hold_nxt  = '0;
      end
    endcase

    if (state_nxt == IDLE) begin
      ack_nxt = 1'b0;
    end else if (active && ack) begin
      ack_nxt = 1'b1;
    end
  end

endmodule
